// File: rtl/tri_pix_pkg.sv
// Shared definitions for the triangle pixel writer: record field offsets,
// frame-buffer geometry, FSM state encoding and the RGB565 packer.
package tri_pix_pkg;

   localparam int unsigned SCREEN_W_DEF = 320;
   localparam int unsigned SCREEN_H_DEF = 240;
   localparam int unsigned FB_DEPTH     = 76800;
   localparam int unsigned FB_AW        = 17;

   localparam int unsigned REC_W  = 299;
   localparam int unsigned X_LSB  = 290;
   localparam int unsigned X_W    = 9;
   localparam int unsigned Y_LSB  = 282;
   localparam int unsigned Y_W    = 8;
   localparam int unsigned C2_LSB = 242;
   localparam int unsigned C1_LSB = 162;
   localparam int unsigned C0_LSB = 82;
   localparam int unsigned U_LSB  = 21;
   localparam int unsigned V_LSB  = 0;
   localparam int unsigned UV_W   = 21;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_MUL,
      ST_SUM,
      ST_WRITE
   } state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   function automatic logic [15:0] pack_rgb565(input rgb888_t c);
      return {c.r[7:3], c.g[7:2], c.b[7:3]};
   endfunction

endpackage

// File: rtl/tri_pix_writer_interp.sv
// One colour channel: registered MUL stage then registered SUM/clamp stage.
// PIX_COLOR_INTERP_EN selects Gouraud interpolation; otherwise vertex0 is piped through.
module tri_color_interp
   import tri_pix_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mul_en,
   input  logic               sum_en,
   input  logic [7:0]         c0,
   input  logic [7:0]         c1,
   input  logic [7:0]         c2,
   input  logic signed [20:0] u,
   input  logic signed [20:0] v,
   output logic [7:0]         result
);

`ifdef PIX_COLOR_INTERP_EN
   logic signed [8:0]  d1;
   logic signed [8:0]  d2;
   logic signed [29:0] pu_q;
   logic signed [29:0] pv_q;
   logic [7:0]         c0_q;
   logic signed [31:0] s;

   assign d1 = $signed({1'b0, c1}) - $signed({1'b0, c0});
   assign d2 = $signed({1'b0, c2}) - $signed({1'b0, c0});
   assign s  = $signed({4'b0000, c0_q, 20'd0}) + 32'(pu_q) + 32'(pv_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pu_q   <= '0;
         pv_q   <= '0;
         c0_q   <= '0;
         result <= '0;
      end else begin
         if (mul_en) begin
            pu_q <= 30'(u) * 30'(d1);
            pv_q <= 30'(v) * 30'(d2);
            c0_q <= c0;
         end
         // non-negative s at or above 256<<20 has a bit set in [30:28]
         if (sum_en) begin
            if (s[31])
               result <= '0;
            else if (s[30:28] != 3'b000)
               result <= '1;
            else
               result <= s[27:20];
         end
      end
   end
`else
   logic [7:0] c0_q;
   logic       unused_ops;

   assign unused_ops = ^{c1, c2, u, v};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c0_q   <= '0;
         result <= '0;
      end else begin
         if (mul_en) c0_q <= c0;
         if (sum_en) result <= c0_q;
      end
   end
`endif

endmodule

// File: rtl/tri_pix_writer.sv
// Final raster stage: interpolates pixel colour, writes RGB565 to the frame buffer,
// and clears the buffer between frames. Macro PIX_COLOR_INTERP_EN enables Gouraud shading.
module tri_pix_writer
   import tri_pix_pkg::*;
#(
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         ras_en_i,
   input  logic         pix_valid_i,
   output logic         pix_ready_o,
   input  logic [298:0] pix_data_i,
   output logic         fb_we_o,
   output logic [16:0]  fb_addr_o,
   output logic [15:0]  fb_din_o,
   output logic         clear_busy_o,
   output logic [15:0]  drop_cnt_o
);

   localparam int unsigned      DEPTH     = SCREEN_W * SCREEN_H;
   localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(DEPTH - 1);

   state_t             state_q;
   state_t             state_d;
   logic [FB_AW-1:0]   clr_addr_q;
   logic               cleared_q;
   logic [X_W-1:0]     x_q;
   logic [Y_W-1:0]     y_q;
   rgb888_t            c0_q;
   rgb888_t            c1_q;
   rgb888_t            c2_q;
   logic signed [20:0] u_q;
   logic signed [20:0] v_q;
   rgb888_t            color;

   logic               accept;
   logic               last_clear;
   logic               on_screen;
   logic [FB_AW-1:0]   pix_addr;
   logic               we_d;
   logic               ready_d;
   logic [FB_AW-1:0]   addr_d;
   logic [15:0]        din_d;
   logic               unused_bits;

   assign accept     = (state_q == ST_IDLE) && pix_valid_i && pix_ready_o;
   assign last_clear = (clr_addr_q == LAST_ADDR);
   assign on_screen  = (32'(x_q) < SCREEN_W) && (32'(y_q) < SCREEN_H);
   assign pix_addr   = FB_AW'(32'(y_q) * SCREEN_W + 32'(x_q));

   // depth values and the spare vertex bits are not needed past the depth test
   assign unused_bits = ^{pix_data_i[281:266], pix_data_i[241:186],
                          pix_data_i[161:106], pix_data_i[81:42]};

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = fb_addr_o;
      din_d   = fb_din_o;
      case (state_q)
         ST_CLEAR: begin
            we_d   = 1'b1;
            addr_d = clr_addr_q;
            din_d  = BG_COLOR;
            if (last_clear) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (accept)
               state_d = ST_MUL;
            else if (!ras_en_i && !cleared_q)
               state_d = ST_CLEAR;
         end
         ST_MUL:   state_d = ST_SUM;
         ST_SUM:   state_d = ST_WRITE;
         ST_WRITE: begin
            state_d = ST_IDLE;
            if (on_screen) begin
               we_d   = 1'b1;
               addr_d = pix_addr;
               din_d  = pack_rgb565(color);
            end
         end
         default:  state_d = ST_CLEAR;
      endcase
      // ready is registered from the next state so a new record can land on the
      // same edge the previous pixel's write is captured
      ready_d = (state_d == ST_IDLE) && ras_en_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= ST_CLEAR;
         pix_ready_o  <= 1'b0;
         fb_we_o      <= 1'b0;
         fb_addr_o    <= '0;
         fb_din_o     <= '0;
         clear_busy_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         pix_ready_o  <= ready_d;
         fb_we_o      <= we_d;
         fb_addr_o    <= addr_d;
         fb_din_o     <= din_d;
         clear_busy_o <= (state_q == ST_CLEAR);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         clr_addr_q <= '0;
         cleared_q  <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         c0_q       <= '0;
         c1_q       <= '0;
         c2_q       <= '0;
         u_q        <= '0;
         v_q        <= '0;
         drop_cnt_o <= '0;
      end else begin
         if (state_q == ST_CLEAR)
            clr_addr_q <= last_clear ? '0 : clr_addr_q + 1'b1;

         if (state_q == ST_CLEAR && last_clear)
            cleared_q <= 1'b1;
         else if (state_q == ST_IDLE && ras_en_i)
            cleared_q <= 1'b0;

         if (accept) begin
            x_q  <= pix_data_i[X_LSB +: X_W];
            y_q  <= pix_data_i[Y_LSB +: Y_W];
            c0_q <= pix_data_i[C0_LSB +: 24];
            c1_q <= pix_data_i[C1_LSB +: 24];
            c2_q <= pix_data_i[C2_LSB +: 24];
            u_q  <= pix_data_i[U_LSB +: UV_W];
            v_q  <= pix_data_i[V_LSB +: UV_W];
         end

         if (state_q == ST_WRITE && !on_screen && drop_cnt_o != 16'hFFFF)
            drop_cnt_o <= drop_cnt_o + 1'b1;
      end
   end

   tri_color_interp u_interp_r (
      .clk    (clk_i),
      .rst_n  (reset_n_i),
      .mul_en (state_q == ST_MUL),
      .sum_en (state_q == ST_SUM),
      .c0     (c0_q.r),
      .c1     (c1_q.r),
      .c2     (c2_q.r),
      .u      (u_q),
      .v      (v_q),
      .result (color.r)
   );

   tri_color_interp u_interp_g (
      .clk    (clk_i),
      .rst_n  (reset_n_i),
      .mul_en (state_q == ST_MUL),
      .sum_en (state_q == ST_SUM),
      .c0     (c0_q.g),
      .c1     (c1_q.g),
      .c2     (c2_q.g),
      .u      (u_q),
      .v      (v_q),
      .result (color.g)
   );

   tri_color_interp u_interp_b (
      .clk    (clk_i),
      .rst_n  (reset_n_i),
      .mul_en (state_q == ST_MUL),
      .sum_en (state_q == ST_SUM),
      .c0     (c0_q.b),
      .c1     (c1_q.b),
      .c2     (c2_q.b),
      .u      (u_q),
      .v      (v_q),
      .result (color.b)
   );

endmodule

// File: tb/tb_tri_pix_writer.sv
// Scoreboard bench for tri_pix_writer: clear sweep, directed pixels, drops,
// streaming throughput and reset abort.
module tb_tri_pix_writer;

   localparam logic [15:0] BG = 16'h5A3C;
`ifdef PIX_COLOR_INTERP_EN
   localparam bit GOURAUD = 1'b1;
`else
   localparam bit GOURAUD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         ras_en = 1'b0;
   logic         pix_valid = 1'b0;
   logic [298:0] pix_data = '0;
   logic         pix_ready;
   logic         fb_we;
   logic [16:0]  fb_addr;
   logic [15:0]  fb_din;
   logic         clear_busy;
   logic [15:0]  drop_cnt;

   tri_pix_writer #(.SCREEN_W(320), .SCREEN_H(240), .BG_COLOR(BG)) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .ras_en_i     (ras_en),
      .pix_valid_i  (pix_valid),
      .pix_ready_o  (pix_ready),
      .pix_data_i   (pix_data),
      .fb_we_o      (fb_we),
      .fb_addr_o    (fb_addr),
      .fb_din_o     (fb_din),
      .clear_busy_o (clear_busy),
      .drop_cnt_o   (drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [16:0] addr;
      logic [15:0] data;
      int          edge_n;
   } exp_t;
   exp_t exp_q[$];

   int   clr_idx = 0;
   int   clr_bad = 0;
   int   sweeps = 0;
   logic prev_busy = 1'b0;
   int   drops_exp = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [298:0] make_rec(input int x, input int y,
                                             input logic [23:0] c0, input logic [23:0] c1,
                                             input logic [23:0] c2,
                                             input logic [20:0] u, input logic [20:0] v);
      logic [298:0] r;
      r = '1;
      r[298:290] = 9'(x);
      r[289:282] = 8'(y);
      r[265:242] = c2;
      r[185:162] = c1;
      r[105:82]  = c0;
      r[41:21]   = u;
      r[20:0]    = v;
      return r;
   endfunction

   // call at a negedge; returns at the negedge after the accepting edge
   task automatic send(input logic [298:0] rec, input bit expect_wr, input logic [16:0] addr,
                       input logic [15:0] data, input bit keep, output int acc_edge);
      int w;
      w = 0;
      pix_data  = rec;
      pix_valid = 1'b1;
      while (!pix_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) begin
         fail_now("accept_timeout");
         pix_valid = 1'b0;
         acc_edge  = -1;
         return;
      end
      acc_edge = cyc + 1;
      if (expect_wr) exp_q.push_back('{addr, data, acc_edge});
      @(negedge clk);
      if (!keep) pix_valid = 1'b0;
   endtask

   task automatic run_vec(input string name, input int x, input int y,
                          input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2,
                          input logic [20:0] u, input logic [20:0] v, input bit on,
                          input logic [16:0] addr, input logic [15:0] flat, input logic [15:0] gour);
      int e;
      send(make_rec(x, y, c0, c1, c2, u, v), on, addr, GOURAUD ? gour : flat, 1'b0, e);
      if (!on) drops_exp++;
      repeat (2) @(negedge clk);
      check({name, "_ready_busy"}, pix_ready, 0);
      @(negedge clk);
      check({name, "_ready_back"}, pix_ready, 1);
      check({name, "_drop_cnt"}, drop_cnt, drops_exp);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         clr_idx   = 0;
         clr_bad   = 0;
         prev_busy = 1'b0;
      end else begin
         if (fb_we) begin
            if (clear_busy) begin
               if (fb_addr !== 17'(clr_idx) || fb_din !== BG) clr_bad++;
               clr_idx++;
            end else if (exp_q.size() == 0) begin
               fail_now("unexpected_write");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wr_addr", fb_addr, e.addr);
               check("wr_data", fb_din, e.data);
               check("wr_latency", cyc, e.edge_n + 3);
            end
         end
         if (prev_busy && !clear_busy) begin
            check("clear_sweep_len", clr_idx, 76800);
            check("clear_sweep_bad", clr_bad, 0);
            sweeps++;
            clr_idx = 0;
            clr_bad = 0;
         end
         prev_busy = clear_busy;
      end
   end

   initial begin
      int w;
      int e;
      int prev;

      repeat (2) @(negedge clk);
      check("rst_ready", pix_ready, 0);
      check("rst_we", fb_we, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_din", fb_din, 0);
      check("rst_busy", clear_busy, 0);
      check("rst_drop", drop_cnt, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("busy_rise", clear_busy, 1);

      w = 0;
      while (clear_busy && w < 80000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 80000) fail_now("clear_timeout");

      repeat (30) @(negedge clk);
      check("no_second_sweep", clear_busy, 0);
      check("idle_no_write", fb_we, 0);
      @(posedge clk);
      check("sweep_count", sweeps, 1);
      @(negedge clk);

      ras_en = 1'b1;
      @(negedge clk);

      run_vec("red", 10, 2, 24'hFF0000, 24'hFF0000, 24'hFF0000, 21'h0, 21'h0,
              1'b1, 17'd650, 16'hF800, 16'hF800);
      run_vec("half", 5, 0, 24'h000000, 24'hFFFFFF, 24'h000000, 21'h080000, 21'h0,
              1'b1, 17'd5, 16'h0000, 16'h7BEF);
      run_vec("clamp_hi", 0, 100, 24'h000000, 24'hC8C8C8, 24'hC8C8C8, 21'h0FFFFF, 21'h0FFFFF,
              1'b1, 17'd32000, 16'h0000, 16'hFFFF);
      run_vec("clamp_lo", 100, 50, 24'h0A141E, 24'hC8C8C8, 24'hC8C8C8, 21'h100000, 21'h0,
              1'b1, 17'd16100, 16'h08A3, 16'h0000);
      run_vec("corner_mix", 319, 239, 24'h6432C8, 24'h14FA00, 24'hB40A64, 21'h040000, 21'h0C0000,
              1'b1, 17'd76799, 16'h6199, 16'h8A29);
      run_vec("off_x", 320, 0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 21'h0, 21'h0,
              1'b0, 17'd0, 16'h0000, 16'h0000);
      run_vec("off_y", 0, 240, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 21'h0, 21'h0,
              1'b0, 17'd0, 16'h0000, 16'h0000);
      run_vec("off_max", 511, 255, 24'h123456, 24'h123456, 24'h123456, 21'h0, 21'h0,
              1'b0, 17'd0, 16'h0000, 16'h0000);

      prev = -1;
      for (int i = 0; i < 4; i++) begin
         send(make_rec(i, 1, 24'h00FF00, 24'h00FF00, 24'h00FF00, 21'h0, 21'h0),
              1'b1, 17'(320 + i), 16'h07E0, (i < 3), e);
         if (prev >= 0) check("stream_spacing", e - prev, 4);
         prev = e;
      end
      repeat (8) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);

      send(make_rec(7, 7, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 21'h0, 21'h0),
           1'b0, 17'd0, 16'h0000, 1'b0, e);
      @(negedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_we", fb_we, 0);
      check("mid_rst_drop", drop_cnt, 0);
      #1 reset_n = 1'b1;
      repeat (50) @(negedge clk);
      @(posedge clk);
      check("restart_writes", clr_idx, 50);
      check("restart_bad", clr_bad, 0);
      @(negedge clk);
      check("restart_busy", clear_busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
